seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
Sequential unsigned N-bit restoring divider. It is the inverse datapath of the team's shift-add multiplier. Each cycle it shifts the remainder:quotient working pair left by one bit and performs a trial subtraction of the divisor. It sits beside the multiplier in the arithmetic unit and uses the same start/done style of control.

Parameters:
N, 5, operand width in bits (dividend, divisor, quotient, remainder); N >= 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a division; sampled on rising clk
dividend  input  N  unsigned dividend; sampled when start is accepted
divisor  input  N  unsigned divisor; sampled when start is accepted
busy  output  1  high while a division is in progress (state RUN)
done  output  1  single-cycle pulse; quotient/remainder valid and updated
quotient  output  N  registered result quotient
remainder  output  N  registered result remainder
div_by_zero  output  1  set when the accepted divisor was 0; held until next accepted start

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
  - While rst is high: state=IDLE; busy, done, div_by_zero, quotient, remainder, internal working registers and iteration counter all 0.
  - Reset mid-operation aborts the division. No done is produced and outputs return to 0.
- States: IDLE, RUN, DONE.
- start is accepted only in IDLE or DONE. It is ignored in RUN, and operands presented while busy are not sampled.
- Accept with divisor != 0:
  - Latch the divisor into the D register.
  - Working register Q := dividend; working register R := 0 (N+1 bits wide).
  - Counter := N; next state RUN; div_by_zero := 0.
- Accept with divisor == 0:
  - Next state DONE directly.
  - quotient := all ones; remainder := dividend; div_by_zero := 1.
  - done is high in the following cycle (1-cycle latency).
- RUN, one iteration per clock edge:
  - Form {R,Q} shifted left by 1, so the MSB of Q enters the LSB of R.
  - trial = shifted R − D, computed N+1 bits wide.
  - If trial is non-negative (MSB of trial = 0): R := trial and the LSB of Q is 1.
  - Otherwise R keeps the shifted value (restore) and the LSB of Q is 0.
  - Counter decrements each iteration.
  - On the edge that performs the final iteration (counter == 1): quotient := new Q; remainder := low N bits of new R; next state DONE.
- DONE lasts exactly one cycle with done=1, then goes to IDLE unless start is accepted in that cycle (back-to-back operation allowed).
- Latency: a start accepted at edge k gives results on quotient/remainder after edge k+N, with done high for the cycle following edge k+N.
- busy=1 exactly in RUN (N cycles); busy and done are never high together.
- quotient, remainder and div_by_zero hold their values from done until the next completion or reset. They do not change during RUN.
- Invariant at completion (divisor != 0): dividend = quotient*divisor + remainder, with remainder < divisor.
- done and busy are registered outputs with no combinational path from start.

Test Plan:
- N=5, rst pulse, then idle -> all outputs 0; start with divisor=3 accepted on first edge after rst deasserts.
- dividend=27, divisor=4, start 1 cycle -> busy high 5 cycles; done pulse on 6th cycle after accept edge; quotient=6, remainder=3, div_by_zero=0.
- Boundary operands, run in sequence:
  - 31/1 -> q=31, r=0.
  - 3/7 -> q=0, r=3.
  - 31/31 -> q=1, r=0.
  - 0/5 -> q=0, r=0.
  - Randomised sweep of all 31*32 nonzero-divisor pairs, checked against the invariant.
- dividend=13, divisor=0 -> done one cycle after accept, busy never high; q=31, r=13, div_by_zero=1. A following 10/3 -> div_by_zero clears; q=3, r=1.
- Start 20/6; hold start high and change operands to 9/2 during RUN -> ignored; result q=3, r=2. With start still high in the DONE cycle -> 9/2 accepted back-to-back; q=4, r=1 after 5 more cycles.
- Start 25/3, assert rst asynchronously mid-cycle at iteration 3 -> outputs 0 immediately and no done pulse. After release, 25/3 -> q=8, r=1.

Source files
------------

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_restoring_divider
//  Description : Sequential unsigned N-bit restoring divider. One quotient
//                bit is resolved per clock: the {R,Q} working pair is shifted
//                left and the divisor is trial-subtracted from R, restoring
//                R when the trial goes negative.
//  Ports       : clk, rst          - clock, async active-high reset
//                start             - request a division (IDLE/DONE only)
//                dividend, divisor - operands, sampled on accepted start
//                busy              - high while iterating (RUN)
//                done              - one-cycle result-valid pulse
//                quotient,remainder- registered results, held until next
//                                    completion
//                div_by_zero       - accepted divisor was zero
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_restoring_divider #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [N-1:0]  r_d;
    logic [N-1:0]  r_q;
    logic [N:0]    r_r;
    logic [CW-1:0] r_cnt;

    logic          w_accept;
    logic          w_div_zero;
    logic          w_last;
    logic [N:0]    w_r_sh;
    logic [N:0]    w_trial;
    logic [N:0]    w_r_new;
    logic [N-1:0]  w_q_new;

    assign w_accept   = start && (r_state != S_RUN);
    assign w_div_zero = (divisor == '0);
    assign w_last     = (r_cnt == CW'(1));

    // One restoring step. R is always below D before the shift, so the
    // shifted value fits in N+1 bits and the trial MSB is a true sign bit.
    assign w_r_sh  = {r_r[N-1:0], r_q[N-1]};
    assign w_trial = w_r_sh - {1'b0, r_d};
    assign w_r_new = w_trial[N] ? w_r_sh : w_trial;
    assign w_q_new = {r_q[N-2:0], ~w_trial[N]};

    // Status outputs are decoded from the state register only, so there is
    // no combinational path from start.
    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_div_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = w_div_zero ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d         <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            if (w_div_zero) begin
                // Short-circuit: no iterations, saturated quotient.
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                r_d         <= divisor;
                r_q         <= dividend;
                r_r         <= '0;
                r_cnt       <= CW'(N);
                div_by_zero <= 1'b0;
            end
        end else if (r_state == S_RUN) begin
            r_q   <= w_q_new;
            r_r   <= w_r_new;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
                quotient  <= w_q_new;
                remainder <= w_r_new[N-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_restoring_divider
//  Description : Directed self-checking bench for seq_restoring_divider (N=5).
//                Inputs change and outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_restoring_divider;

    localparam int N = 5;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int n_checks;
    int n_fails;

    logic [N-1:0] last_q;
    logic [N-1:0] last_r;

    seq_restoring_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_q"}, 32'(quotient), 32'd0);
        check({tag, "_r"}, 32'(remainder), 32'd0);
        check({tag, "_dz"}, 32'(div_by_zero), 32'd0);
    endtask

    // Full-timing division: start is high for exactly one edge. Called on a
    // falling edge; returns on the falling edge after the done cycle.
    task automatic run_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (b != 0) begin
            for (int i = 0; i < N; i++) begin
                check({tag, "_busy"}, 32'(busy), 32'd1);
                check({tag, "_nodone"}, 32'(done), 32'd0);
                check({tag, "_qhold"}, 32'(quotient), 32'(last_q));
                @(negedge clk);
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
        last_q = eq;
        last_r = er;
        @(negedge clk);
        check({tag, "_pulse_end"}, 32'(done), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        last_q   = '0;
        last_r   = '0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_idle_zero("reset");

        // Release reset with a start pending: accepted on the first edge.
        dividend = 5'd20;
        divisor  = 5'd3;
        start    = 1'b1;
        rst      = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("first_accept_busy", 32'(busy), 32'd1);
        repeat (N) @(negedge clk);
        check("first_done", 32'(done), 32'd1);
        check("first_q", 32'(quotient), 32'd6);
        check("first_r", 32'(remainder), 32'd2);
        last_q = 5'd6;
        last_r = 5'd2;
        @(negedge clk);

        // Main function and boundary operands
        run_div("d27_4", 5'd27, 5'd4, 5'd6, 5'd3, 1'b0);
        run_div("d31_1", 5'd31, 5'd1, 5'd31, 5'd0, 1'b0);
        run_div("d3_7", 5'd3, 5'd7, 5'd0, 5'd3, 1'b0);
        run_div("d31_31", 5'd31, 5'd31, 5'd1, 5'd0, 1'b0);
        run_div("d0_5", 5'd0, 5'd5, 5'd0, 5'd0, 1'b0);

        // Divide by zero, then a normal division clears the flag.
        dividend = 5'd13;
        divisor  = 5'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("dz_done", 32'(done), 32'd1);
        check("dz_busy", 32'(busy), 32'd0);
        check("dz_q", 32'(quotient), 32'd31);
        check("dz_r", 32'(remainder), 32'd13);
        check("dz_flag", 32'(div_by_zero), 32'd1);
        @(negedge clk);
        check("dz_pulse_end", 32'(done), 32'd0);
        check("dz_busy_never", 32'(busy), 32'd0);
        check("dz_flag_hold", 32'(div_by_zero), 32'd1);
        last_q = 5'd31;
        last_r = 5'd13;
        run_div("d10_3", 5'd10, 5'd3, 5'd3, 5'd1, 1'b0);

        // Operands changed during RUN are ignored; start held into DONE
        // launches the next division back to back.
        dividend = 5'd20;
        divisor  = 5'd6;
        start    = 1'b1;
        @(negedge clk);
        dividend = 5'd9;
        divisor  = 5'd2;
        for (int i = 0; i < N; i++) begin
            check("b2b_busy1", 32'(busy), 32'd1);
            check("b2b_qhold1", 32'(quotient), 32'(last_q));
            @(negedge clk);
        end
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_q1", 32'(quotient), 32'd3);
        check("b2b_r1", 32'(remainder), 32'd2);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("b2b_busy2", 32'(busy), 32'd1);
            check("b2b_nodone2", 32'(done), 32'd0);
            check("b2b_qhold2", 32'(quotient), 32'd3);
            @(negedge clk);
        end
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_q2", 32'(quotient), 32'd4);
        check("b2b_r2", 32'(remainder), 32'd1);
        last_q = 5'd4;
        last_r = 5'd1;
        @(negedge clk);

        // Asynchronous reset in the middle of iteration 3.
        dividend = 5'd25;
        divisor  = 5'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_idle_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            check("midrst_nodone", 32'(done), 32'd0);
            check("midrst_nobusy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        last_q = '0;
        last_r = '0;
        run_div("d25_3", 5'd25, 5'd3, 5'd8, 5'd1, 1'b0);

        // Sweep of every nonzero-divisor pair with random idle gaps, checked
        // against the division invariant.
        for (int a = 0; a < 32; a++) begin
            for (int b = 1; b < 32; b++) begin
                int wait_cycles;
                repeat ($urandom_range(0, 1)) @(negedge clk);
                dividend = 5'(a);
                divisor  = 5'(b);
                start    = 1'b1;
                @(negedge clk);
                start = 1'b0;
                wait_cycles = 0;
                while (!done && wait_cycles < 20) begin
                    @(negedge clk);
                    wait_cycles++;
                end
                check("sweep_done", 32'(done), 32'd1);
                check("sweep_invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
                check("sweep_rem_lt", 32'(remainder < 5'(b)), 32'd1);
                check("sweep_dz", 32'(div_by_zero), 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
